// File: rtl/instx_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over req/ack, computes the next PC.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module instx_fetch #(
  parameter int unsigned       PC_W        = 32,
  parameter logic [PC_W-1:0]   RESET_PC    = '0,
  parameter int unsigned       TIMEOUT_CYC = 15
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              IMemReq,
  output logic [PC_W-1:0]   IMemAddr,
  input  logic [31:0]       IMemRdata,
  input  logic              IMemAck,
  input  logic              Advance,
  input  logic              PCC,
  input  logic              BSC,
  input  logic              BGR,
  input  logic              FlagN,
  input  logic              FlagZ,
  input  logic              FlagV,
  input  logic [PC_W-1:0]   RegTarget,
  output logic              InstxValid,
  output logic [31:0]       Instx,
  output logic [10:0]       InstxOp,
  output logic [PC_W-1:0]   InstxPC,
  output logic              FetchErr
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_t;

  state_t            r_state, w_state_nxt;
  logic [PC_W-1:0]   r_pc, w_pc_nxt;
  logic              r_req, w_req_nxt;
  logic [31:0]       r_instx, w_instx_nxt;
  logic [10:0]       r_op, w_op_nxt;
  logic [PC_W-1:0]   r_ipc, w_ipc_nxt;
  logic              r_valid, w_valid_nxt;

  logic [PC_W-1:0]   w_off26, w_off19, w_npc;
  logic              w_gt;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_err, w_err_nxt;
`endif

  // Branch offsets are word offsets, sign-extended then scaled to bytes.
  assign w_off26 = {{(PC_W-26){r_instx[25]}}, r_instx[25:0]} << 2;
  assign w_off19 = {{(PC_W-19){r_instx[23]}}, r_instx[23:5]} << 2;
  assign w_gt    = !FlagZ && (FlagN == FlagV);

  always_comb begin
    w_npc = r_ipc + PC_W'(4);
    if (PCC && BSC)       w_npc = RegTarget;
    else if (PCC)         w_npc = r_ipc + w_off26;
    else if (BGR && w_gt) w_npc = r_ipc + w_off19;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_req_nxt   = r_req;
    w_instx_nxt = r_instx;
    w_op_nxt    = r_op;
    w_ipc_nxt   = r_ipc;
    w_valid_nxt = r_valid;
`ifdef FETCH_TIMEOUT_EN
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_FETCH;
        w_req_nxt   = 1'b1;
`ifdef FETCH_TIMEOUT_EN
        w_cnt_nxt   = '0;
`endif
      end
      S_FETCH: begin
        if (IMemAck) begin
          w_instx_nxt = IMemRdata;
          w_op_nxt    = IMemRdata[31:21];
          w_ipc_nxt   = r_pc;
          w_valid_nxt = 1'b1;
          w_req_nxt   = 1'b0;
          w_state_nxt = S_VALID;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (r_cnt == CNT_LAST) begin
          // Watchdog expiry hands the decoder a NOP so the core can move on.
          w_instx_nxt = '0;
          w_op_nxt    = '0;
          w_ipc_nxt   = r_pc;
          w_valid_nxt = 1'b1;
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_VALID;
        end else begin
          w_cnt_nxt   = r_cnt + 1'b1;
        end
`endif
      end
      S_VALID: begin
        if (Advance) begin
          w_pc_nxt    = w_npc;
          w_valid_nxt = 1'b0;
          w_op_nxt    = '0;
          w_req_nxt   = 1'b1;
          w_state_nxt = S_FETCH;
`ifdef FETCH_TIMEOUT_EN
          w_cnt_nxt   = '0;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state <= S_IDLE;
      r_pc    <= RESET_PC;
      r_req   <= 1'b0;
      r_instx <= '0;
      r_op    <= '0;
      r_ipc   <= RESET_PC;
      r_valid <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_req   <= w_req_nxt;
      r_instx <= w_instx_nxt;
      r_op    <= w_op_nxt;
      r_ipc   <= w_ipc_nxt;
      r_valid <= w_valid_nxt;
`ifdef FETCH_TIMEOUT_EN
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
`endif
    end
  end

  assign IMemReq    = r_req;
  assign IMemAddr   = r_pc;
  assign InstxValid = r_valid;
  assign Instx      = r_instx;
  assign InstxOp    = r_op;
  assign InstxPC    = r_ipc;
`ifdef FETCH_TIMEOUT_EN
  assign FetchErr   = r_err;
`else
  assign FetchErr   = 1'b0;
`endif

endmodule

// File: tb/tb_instx_fetch.sv
// Testbench for instx_fetch: directed branch/handshake cases plus random traffic against a transaction-level model.
module tb_instx_fetch;

  localparam int TMO = 15;

  logic        Clock, Reset;
  logic        IMemReq, IMemAck, Advance, PCC, BSC, BGR, FlagN, FlagZ, FlagV;
  logic        InstxValid, FetchErr;
  logic [31:0] IMemAddr, IMemRdata, RegTarget, Instx, InstxPC;
  logic [10:0] InstxOp;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the fetch stage should be presenting.
  logic [31:0] m_pc, m_instx, m_ipc;
  bit          m_req, m_valid, m_err;
  int          m_wait;
  logic [31:0] addrq[$];

  instx_fetch #(.PC_W(32), .RESET_PC(32'h0), .TIMEOUT_CYC(TMO)) dut (
    .Clock(Clock), .Reset(Reset),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemRdata(IMemRdata), .IMemAck(IMemAck),
    .Advance(Advance), .PCC(PCC), .BSC(BSC), .BGR(BGR),
    .FlagN(FlagN), .FlagZ(FlagZ), .FlagV(FlagV), .RegTarget(RegTarget),
    .InstxValid(InstxValid), .Instx(Instx), .InstxOp(InstxOp), .InstxPC(InstxPC),
    .FetchErr(FetchErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_npc(input logic [31:0] ins, input logic [31:0] ipc);
    longint off;
    if (PCC && BSC) return RegTarget;
    if (PCC) begin
      off = longint'(ins[25:0]);
      if (ins[25]) off -= longint'(1) << 26;
      return 32'(longint'(ipc) + off * 4);
    end
    if (BGR && !FlagZ && (FlagN == FlagV)) begin
      off = longint'(ins[23:5]);
      if (ins[23]) off -= longint'(1) << 19;
      return 32'(longint'(ipc) + off * 4);
    end
    return 32'(longint'(ipc) + 4);
  endfunction

  task automatic model_reset();
    m_pc = '0; m_instx = '0; m_ipc = '0;
    m_req = 0; m_valid = 0; m_err = 0; m_wait = 0;
  endtask

  task automatic check_all();
    check_eq("IMemReq",    32'(IMemReq),    32'(m_req));
    check_eq("IMemAddr",   IMemAddr,        m_pc);
    check_eq("InstxValid", 32'(InstxValid), 32'(m_valid));
    check_eq("InstxOp",    32'(InstxOp),    m_valid ? 32'(m_instx[31:21]) : 32'h0);
    check_eq("InstxPC",    InstxPC,         m_ipc);
    check_eq("Instx",      Instx,           m_instx);
    check_eq("FetchErr",   32'(FetchErr),   32'(m_err));
  endtask

  // One clock: update the model from the inputs now being driven, then check after the edge.
  task automatic step();
    if (!m_req && !m_valid) begin
      m_req = 1; m_wait = 0;
    end else if (m_req) begin
      if (IMemAck) begin
        m_instx = IMemRdata; m_ipc = m_pc; m_valid = 1; m_req = 0;
      end
`ifdef FETCH_TIMEOUT_EN
      else begin
        m_wait++;
        if (m_wait == TMO) begin
          m_instx = '0; m_ipc = m_pc; m_valid = 1; m_req = 0; m_err = 1;
        end
      end
`endif
    end else if (Advance) begin
      m_pc = ref_npc(m_instx, m_ipc); m_valid = 0; m_req = 1; m_wait = 0;
    end
    @(posedge Clock);
    @(negedge Clock);
    check_all();
  endtask

  task automatic clear_ctl();
    Advance = 0; PCC = 0; BSC = 0; BGR = 0; FlagN = 0; FlagZ = 0; FlagV = 0; RegTarget = '0;
  endtask

  task automatic fetch_word(input logic [31:0] word);
    IMemAck = 1; IMemRdata = word; Advance = 0;
    step();
    IMemAck = 0;
  endtask

  task automatic adv(input bit pcc, input bit bsc, input bit bgr, input bit n, input bit z,
                     input bit v, input logic [31:0] rt);
    IMemAck = 0; Advance = 1; PCC = pcc; BSC = bsc; BGR = bgr;
    FlagN = n; FlagZ = z; FlagV = v; RegTarget = rt;
    step();
    clear_ctl();
  endtask

  task automatic jump_fetch(input logic [31:0] tgt, input logic [31:0] word);
    adv(1, 1, 0, 0, 0, 0, tgt);
    fetch_word(word);
  endtask

  initial begin
    Reset = 0; IMemAck = 0; IMemRdata = '0;
    clear_ctl();
    model_reset();
    repeat (2) @(negedge Clock);
    check_all();

    // Back-to-back fetches with same-cycle ack; walk PC up to 0x10.
    Reset = 1;
    IMemAck = 1;
    for (int i = 0; i < 40; i++) begin
      if (m_valid && m_ipc == 32'h10) break;
      IMemRdata = (IMemAddr == 32'h10) ? 32'h17FF_FFFE : 32'h8B02_0020;
      Advance = 1;
      step();
      if (m_ipc != 32'h10) check_eq("op_seq", 32'(InstxOp), InstxValid ? 32'h458 : 32'h0);
      if (IMemReq && (addrq.size() == 0 || addrq[$] != IMemAddr)) addrq.push_back(IMemAddr);
    end
    Advance = 0; IMemAck = 0;
    check_eq("reach_0x10", InstxPC, 32'h10);
    if (addrq.size() < 3) check_eq("addr_seq_len", 32'(addrq.size()), 32'd3);
    else begin
      check_eq("addr_seq0", addrq[0], 32'h0);
      check_eq("addr_seq1", addrq[1], 32'h4);
      check_eq("addr_seq2", addrq[2], 32'h8);
    end

    adv(1, 0, 0, 0, 0, 0, 32'h0);
    check_eq("br_imm26", IMemAddr, 32'h08);
    fetch_word(32'h8B02_0020);
    adv(1, 1, 0, 0, 0, 0, 32'h100);
    check_eq("br_reg", IMemAddr, 32'h100);
    fetch_word(32'h8B02_0020);

    jump_fetch(32'h20, 32'h5400_006C);
    adv(0, 0, 1, 0, 0, 0, 32'h0);
    check_eq("bgr_taken", IMemAddr, 32'h2C);
    fetch_word(32'h8B02_0020);
    jump_fetch(32'h20, 32'h5400_006C);
    adv(0, 0, 1, 0, 1, 0, 32'h0);
    check_eq("bgr_not_taken", IMemAddr, 32'h24);
    fetch_word(32'h8B02_0020);
    jump_fetch(32'h20, 32'h5400_006C);
    adv(1, 1, 1, 0, 0, 0, 32'h40);
    check_eq("pcc_over_bgr", IMemAddr, 32'h40);

    // Delayed ack with stray Advance pulses during FETCH.
    for (int i = 0; i < 3; i++) begin
      IMemAck = 0; Advance = 1;
      step();
      check_eq("wait_req",   32'(IMemReq),    32'h1);
      check_eq("wait_addr",  IMemAddr,        32'h40);
      check_eq("wait_valid", 32'(InstxValid), 32'h0);
      check_eq("wait_op",    32'(InstxOp),    32'h0);
    end
    Advance = 0;
    fetch_word(32'h8B02_0020);
    check_eq("late_ack_pc", InstxPC, 32'h40);

    // Asynchronous reset while holding an instruction at 0x30.
    jump_fetch(32'h30, 32'h8B02_0020);
    check_eq("pre_rst_valid", 32'(InstxValid), 32'h1);
    Reset = 0;
    #1;
    model_reset();
    check_all();
    @(negedge Clock);
    Reset = 1;
    step();
    check_eq("post_rst_addr", IMemAddr, 32'h0);
    check_eq("post_rst_req",  32'(IMemReq), 32'h1);

`ifdef FETCH_TIMEOUT_EN
    IMemAck = 0;
    for (int i = 0; i < TMO; i++) step();
    check_eq("tmo_req",   32'(IMemReq),    32'h0);
    check_eq("tmo_valid", 32'(InstxValid), 32'h1);
    check_eq("tmo_instx", Instx,           32'h0);
    check_eq("tmo_err",   32'(FetchErr),   32'h1);
    adv(0, 0, 0, 0, 0, 0, 32'h0);
    check_eq("tmo_adv_addr", IMemAddr, 32'h4);
    fetch_word(32'h8B02_0020);
    check_eq("tmo_err_sticky", 32'(FetchErr), 32'h1);
`else
    fetch_word(32'h8B02_0020);
`endif

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      IMemAck   = ($urandom_range(0, 3) != 0);
      IMemRdata = $urandom;
      Advance   = $urandom_range(0, 1);
      PCC       = ($urandom_range(0, 3) == 0);
      BSC       = $urandom_range(0, 1);
      BGR       = $urandom_range(0, 1);
      FlagN     = $urandom_range(0, 1);
      FlagZ     = $urandom_range(0, 1);
      FlagV     = $urandom_range(0, 1);
      RegTarget = $urandom;
      step();
    end
    clear_ctl();
    IMemAck = 0;

    Reset = 0;
    #1;
    model_reset();
    check_all();
    @(negedge Clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instx_fetch.md
Name: instx_fetch

Overview:
Instruction fetch stage that sits directly upstream of the control decoder. It owns the program counter and fetches 32-bit instruction words from instruction memory over a req/ack handshake. It holds one instruction at a time and presents InstxOp (Instx[31:21]) to the decoder. It computes the next PC from the decoder's branch controls (PCC, BSC, BGR), the ALU flags and a register-sourced target. Non-pipelined: one instruction is in flight at a time.

Parameters:
PC_W, 32, width of PC and instruction-memory byte address
RESET_PC, 0, PC value loaded on reset
TIMEOUT_CYC, 15, fetch watchdog limit in cycles (used only with FETCH_TIMEOUT_EN)

Ports:
Clock  input  1  clock, rising edge
Reset  input  1  asynchronous, active-low reset
IMemReq  output  1  fetch request to instruction memory
IMemAddr  output  PC_W  fetch byte address, equal to current PC
IMemRdata  input  32  instruction word, valid when IMemAck=1
IMemAck  input  1  memory accepts request / data valid this cycle
Advance  input  1  current instruction retired; branch controls valid this cycle
PCC  input  1  unconditional branch taken
BSC  input  1  branch source when PCC=1: 0 = imm26, 1 = RegTarget
BGR  input  1  conditional branch-greater-than
FlagN, FlagZ, FlagV  input  1 each  ALU flags
RegTarget  input  PC_W  register branch target (BR)
InstxValid  output  1  Instx/InstxOp hold a fetched instruction
Instx  output  32  held instruction word
InstxOp  output  11  Instx[31:21] when valid, else 11'h000 (NOP)
InstxPC  output  PC_W  address of the held instruction
FetchErr  output  1  sticky fetch timeout flag

Behaviour:
- Reset (Reset=0, asynchronous, takes effect immediately in any state):
  - PC=RESET_PC, state=IDLE.
  - IMemReq=0, IMemAddr=RESET_PC, InstxValid=0, Instx=0, InstxOp=0, InstxPC=RESET_PC, FetchErr=0.
- All outputs are registered.
- IDLE: unconditionally goes to FETCH on the next posedge, which sets IMemReq=1.
- FETCH:
  - IMemReq=1 and IMemAddr=PC, both held stable until IMemAck.
  - At a posedge with IMemAck=1: Instx<=IMemRdata, InstxOp<=IMemRdata[31:21], InstxPC<=PC, InstxValid<=1, IMemReq<=0, state<=VALID.
  - Ack in the same cycle as the request is legal.
- VALID:
  - Instx, InstxOp and InstxPC are held.
  - At a posedge with Advance=1: PC<=next PC, InstxValid<=0, InstxOp<=0, IMemReq<=1, IMemAddr<=next PC, state<=FETCH.
- Ignored events: Advance outside VALID; IMemAck outside FETCH.
- Minimum throughput: 2 cycles per instruction.
- Next PC, evaluated in the Advance cycle, priority order:
  1. PCC=1, BSC=1: RegTarget.
  2. PCC=1, BSC=0: InstxPC + (sext(Instx[25:0])<<2).
  3. BGR=1 and GT, where GT = !FlagZ & (FlagN==FlagV): InstxPC + (sext(Instx[23:5])<<2).
  4. Otherwise: InstxPC + 4.
- PCC has priority over BGR if both are asserted.
- All PC arithmetic is modulo 2^PC_W; wrap-around is silent.
- RegTarget is used unaligned as-is; no alignment check.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A counter counts FETCH cycles without IMemAck and clears on entry to FETCH.
  - When the count reaches TIMEOUT_CYC: state<=VALID, Instx<=0, InstxOp<=0 (NOP), InstxValid<=1, IMemReq<=0, FetchErr<=1.
  - FetchErr is sticky until Reset.
  - Advance then proceeds as normal, using PC+4.
- Undefined: FETCH waits indefinitely; FetchErr is tied to 0.

Test Plan:
- Reset then release, memory acks in the request cycle with 0x8B020020 at every address -> IMemAddr sequence 0x0, 0x4, 0x8 with Advance every VALID cycle; InstxOp=0x458 while InstxValid=1, 0x000 otherwise.
- Instx 0x17FFFFFE at InstxPC 0x10, Advance with PCC=1, BSC=0 -> next IMemAddr 0x08.
- Advance with PCC=1, BSC=1, RegTarget=0x100 -> next IMemAddr 0x100.
- Instx 0x5400006C at 0x20, BGR=1:
  - N=Z=V=0 -> next IMemAddr 0x2C.
  - Z=1 -> next IMemAddr 0x24.
  - PCC=1, BSC=1, RegTarget=0x40 at the same time -> 0x40.
- IMemAck delayed 3 cycles, Advance pulsed during FETCH -> IMemReq=1 and IMemAddr stable for 4 cycles; InstxValid=0 and InstxOp=0 throughout; Advance has no effect.
- Reset pulsed low mid-VALID at PC 0x30 -> outputs return to reset values asynchronously; the first fetch after release is at RESET_PC. With FETCH_TIMEOUT_EN and no ack, IMemReq drops after 15 cycles, InstxValid=1, Instx=0, FetchErr=1, and FetchErr stays 1 until Reset.
